// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: walks the PC through instruction memory, assembles
// one- or two-word instructions, issues them downstream and handles jumps and HALT.
module fetch_unit #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] pc_addr,
  output logic          pc_rd_en,
  output logic          pc_inc,
  output logic          pc_wr_en,
  output logic [AW-1:0] pc_wr_data,
  input  logic          pc_ovf,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_valid,
  input  logic [DW-1:0] imem_data,
  input  logic          jmp_en,
  input  logic [AW-1:0] jmp_target,
  output logic [DW-1:0] ir_opcode,
  output logic [DW-1:0] ir_operand,
  output logic          ir_valid,
  input  logic          ir_ready,
  output logic          halted,
  output logic          err_ovf
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_REQ_OP   = 3'd1;
  localparam logic [2:0] S_WAIT_OP  = 3'd2;
  localparam logic [2:0] S_REQ_ARG  = 3'd3;
  localparam logic [2:0] S_WAIT_ARG = 3'd4;
  localparam logic [2:0] S_ISSUE    = 3'd5;
  localparam logic [2:0] S_FLUSH    = 3'd6;
  localparam logic [2:0] S_HALT     = 3'd7;

  localparam logic [DW-1:0] OP_HALT = {DW{1'b1}};

  logic [2:0]    state_q, state_d;
  logic          imem_req_q, imem_req_d;
  logic          pc_rd_en_q, pc_rd_en_d;
  logic          pc_inc_q, pc_inc_d;
  logic          pc_wr_en_q, pc_wr_en_d;
  logic [AW-1:0] pc_wr_data_q, pc_wr_data_d;
  logic [AW-1:0] imem_addr_q, imem_addr_d;
  logic [DW-1:0] ir_opcode_q, ir_opcode_d;
  logic [DW-1:0] ir_operand_q, ir_operand_d;
  logic          ir_valid_q, ir_valid_d;
  logic          halted_q, halted_d;
  logic          err_ovf_q, err_ovf_d;

  logic          jmp_take_c;
  logic          req_live_c;
  logic          arm_c;

  // Jumps are honoured only while fetching or issuing.
  assign jmp_take_c = jmp_en && (state_q inside {S_REQ_OP, S_WAIT_OP, S_REQ_ARG,
                                                 S_WAIT_ARG, S_ISSUE});

  // A request is in flight if it is being driven now, or awaited without its data this cycle.
  assign req_live_c = ((state_q == S_REQ_OP  || state_q == S_REQ_ARG)  && imem_req_q) ||
                      ((state_q == S_WAIT_OP || state_q == S_WAIT_ARG) && !imem_valid);

  always_comb begin
    state_d      = state_q;
    imem_req_d   = 1'b0;
    pc_rd_en_d   = 1'b0;
    pc_inc_d     = 1'b0;
    pc_wr_en_d   = 1'b0;
    pc_wr_data_d = pc_wr_data_q;
    imem_addr_d  = imem_addr_q;
    ir_opcode_d  = ir_opcode_q;
    ir_operand_d = ir_operand_q;
    ir_valid_d   = ir_valid_q;
    halted_d     = halted_q;
    err_ovf_d    = err_ovf_q | pc_ovf;
    arm_c        = 1'b0;

    if (jmp_take_c) begin
      pc_wr_en_d   = 1'b1;
      pc_wr_data_d = jmp_target;
      ir_valid_d   = 1'b0;
      state_d      = req_live_c ? S_FLUSH : S_REQ_OP;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_REQ_OP;
            arm_c   = 1'b1;
          end
        end
        // Entered with the request already armed, except right after a jump load.
        S_REQ_OP: begin
          if (imem_req_q) state_d = S_WAIT_OP;
          else            arm_c   = 1'b1;
        end
        S_WAIT_OP: begin
          if (imem_valid) begin
            if (imem_data == OP_HALT) begin
              state_d  = S_HALT;
              halted_d = 1'b1;
            end else if (imem_data[DW-1]) begin
              ir_opcode_d = imem_data;
              state_d     = S_REQ_ARG;
              arm_c       = 1'b1;
            end else begin
              ir_opcode_d  = imem_data;
              ir_operand_d = '0;
              ir_valid_d   = 1'b1;
              state_d      = S_ISSUE;
            end
          end
        end
        S_REQ_ARG: begin
          if (imem_req_q) state_d = S_WAIT_ARG;
          else            arm_c   = 1'b1;
        end
        S_WAIT_ARG: begin
          if (imem_valid) begin
            ir_operand_d = imem_data;
            ir_valid_d   = 1'b1;
            state_d      = S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (ir_ready) begin
            ir_valid_d = 1'b0;
            state_d    = S_REQ_OP;
            arm_c      = 1'b1;
          end
        end
        S_FLUSH: begin
          if (imem_valid) begin
            state_d = S_REQ_OP;
            arm_c   = 1'b1;
          end
        end
        S_HALT: begin
          halted_d = 1'b1;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // The PC moves on the falling edge, so pc_addr is current for the next request.
    if (arm_c) begin
      imem_req_d  = 1'b1;
      pc_rd_en_d  = 1'b1;
      pc_inc_d    = 1'b1;
      imem_addr_d = pc_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      imem_req_q   <= 1'b0;
      pc_rd_en_q   <= 1'b0;
      pc_inc_q     <= 1'b0;
      pc_wr_en_q   <= 1'b0;
      pc_wr_data_q <= '0;
      imem_addr_q  <= '0;
      ir_opcode_q  <= '0;
      ir_operand_q <= '0;
      ir_valid_q   <= 1'b0;
      halted_q     <= 1'b0;
      err_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      imem_req_q   <= imem_req_d;
      pc_rd_en_q   <= pc_rd_en_d;
      pc_inc_q     <= pc_inc_d;
      pc_wr_en_q   <= pc_wr_en_d;
      pc_wr_data_q <= pc_wr_data_d;
      imem_addr_q  <= imem_addr_d;
      ir_opcode_q  <= ir_opcode_d;
      ir_operand_q <= ir_operand_d;
      ir_valid_q   <= ir_valid_d;
      halted_q     <= halted_d;
      err_ovf_q    <= err_ovf_d;
    end
  end

  assign imem_req   = imem_req_q;
  assign pc_rd_en   = pc_rd_en_q;
  assign pc_inc     = pc_inc_q;
  assign pc_wr_en   = pc_wr_en_q;
  assign pc_wr_data = pc_wr_data_q;
  assign imem_addr  = imem_addr_q;
  assign ir_opcode  = ir_opcode_q;
  assign ir_operand = ir_operand_q;
  assign ir_valid   = ir_valid_q;
  assign halted     = halted_q;
  assign err_ovf    = err_ovf_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter AW, default 10, instruction address width; matches the 10-bit PC.
REQ-002 Parameter DW, default 8, instruction word width.
REQ-003 clk  in  1  system clock; all state in this block changes on posedge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  single-cycle pulse that leaves IDLE and begins fetching.
REQ-006 pc_addr  in  AW  current PC value, driven from the PC direct-read port.
REQ-007 pc_rd_en  out  1  enable for the PC direct-read port.
REQ-008 pc_inc  out  1  one-cycle increment pulse to the PC.
REQ-009 pc_wr_en  out  1  PC load enable.
REQ-010 pc_wr_data  out  AW  PC load value.
REQ-011 pc_ovf  in  1  PC overflow flag.
REQ-012 imem_req  out  1  instruction-memory read request; one cycle per word.
REQ-013 imem_addr  out  AW  instruction-memory read address.
REQ-014 imem_valid  in  1  read data valid; arrives 1 or more cycles after imem_req.
REQ-015 imem_data  in  DW  read data.
REQ-016 jmp_en  in  1  jump request from execute.
REQ-017 jmp_target  in  AW  jump destination.
REQ-018 ir_opcode  out  DW  issued opcode.
REQ-019 ir_operand  out  DW  issued operand; 0 for one-word instructions.
REQ-020 ir_valid  out  1  issued instruction valid.
REQ-021 ir_ready  in  1  downstream accepts the issued instruction.
REQ-022 halted  out  1  HALT opcode reached.
REQ-023 err_ovf  out  1  sticky flag: PC wrapped past 10'h3FF.

Function
REQ-024 The FSM SHALL have the states IDLE, REQ_OP, WAIT_OP, REQ_ARG, WAIT_ARG, ISSUE, FLUSH and HALT.
REQ-025 IDLE SHALL go to REQ_OP on start; start SHALL be ignored in every other state.
REQ-026 REQ_OP SHALL assert imem_req, pc_rd_en and pc_inc for one cycle, with imem_addr = pc_addr, then go to WAIT_OP.
REQ-027 The PC updates on negedge, so pc_addr SHALL already show the incremented value at the next posedge; no extra wait cycle SHALL be inserted.
REQ-028 WAIT_OP SHALL capture the opcode on imem_valid, as follows.
 - Opcode 8'hFF: go to HALT.
 - Opcode bit7 = 1 (any other value): go to REQ_ARG.
 - Otherwise: set operand to 0 and go to ISSUE.
REQ-029 REQ_ARG and WAIT_ARG SHALL behave like REQ_OP and WAIT_OP but capture ir_operand, then go to ISSUE.
REQ-030 ISSUE SHALL hold ir_valid = 1, and hold ir_opcode and ir_operand stable, until ir_ready = 1; on ir_valid && ir_ready it SHALL go to REQ_OP in the next cycle.
REQ-031 Minimum throughput SHALL be one instruction per 3 cycles for one-word instructions and per 5 cycles for two-word instructions, with single-cycle memory latency.
REQ-032 At most one imem request SHALL be outstanding at any time.
REQ-033 jmp_en has priority in REQ_OP, WAIT_OP, REQ_ARG, WAIT_ARG and ISSUE:
 - assert pc_wr_en for one cycle with pc_wr_data = jmp_target, and suppress pc_inc in that cycle;
 - drop ir_valid;
 - if a request is outstanding, go to FLUSH; otherwise go to REQ_OP.
REQ-034 FLUSH SHALL discard the next imem_valid word and then go to REQ_OP.
REQ-035 jmp_en SHALL be ignored in IDLE, FLUSH and HALT.
REQ-036 pc_wr_en and pc_inc SHALL never be asserted in the same cycle.
REQ-037 HALT SHALL assert halted = 1 and issue no further requests; only rst exits HALT.
REQ-038 err_ovf SHALL set when pc_ovf = 1 is sampled and SHALL clear only on rst; fetching continues from address 0.
REQ-039 imem_valid arriving in any state other than WAIT_OP, WAIT_ARG or FLUSH SHALL be ignored.

Reset
REQ-040 rst SHALL immediately force the following; rst during an outstanding fetch SHALL abandon it without any flush:
 - state = IDLE;
 - ir_valid, imem_req, pc_inc, pc_wr_en, pc_rd_en, halted and err_ovf = 0;
 - ir_opcode, ir_operand, imem_addr and pc_wr_data = 0.

Verification
REQ-041 One-word fetch: PC = 0, mem[0] = 8'h12, 1-cycle latency, start pulse. Required: imem_addr = 0, pc_inc pulses once, ir_opcode = 8'h12, ir_operand = 0, ir_valid 3 cycles after start.
REQ-042 Two-word fetch: mem[5] = 8'h85, mem[6] = 8'h3C, PC = 5. Required: two requests at addresses 5 and 6, ir_opcode = 8'h85, ir_operand = 8'h3C; PC ends at 7.
REQ-043 Backpressure: ir_ready held low for 4 cycles. Required: ir_valid and ir_opcode stable throughout, and no imem_req until the handshake completes.
REQ-044 Jump in WAIT_OP with jmp_target = 10'h200, data returned late. Required: pc_wr_en pulse carrying 10'h200, stale word discarded in FLUSH, next imem_addr = 10'h200.
REQ-045 HALT and wrap-around:
 - mem[PC] = 8'hFF: halted = 1, imem_req stays 0 for 10 cycles, and start is ignored.
 - PC = 10'h3FF with pc_ovf pulse: err_ovf = 1 and the next fetch address is 0.
REQ-046 Reset mid-fetch: rst asserted in WAIT_ARG. Required: all outputs 0 in the same cycle (asynchronous), then state IDLE after rst falls.
